// File: rtl/sensor_packetizer.sv
// sensor_packetizer: snapshots cc/dc every SAMPLE_DIV cycles and streams HEADER, data and checksum
// bytes to a single uart_send. Define SENSOR_PKT_SEQ_EN to insert a sequence byte after HEADER.
module sensor_packetizer #(
    parameter int unsigned SAMPLE_DIV = 32'd10_000_000,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic       fpga_clk1,
    input  logic       rst_n,
    input  logic [7:0] cc_value,
    input  logic [7:0] dc_value,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] pkt_count,
    output logic [2:0] dbg_state_o
);
    localparam int unsigned      CNT_W   = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SAMPLE_DIV - 1);
`ifdef SENSOR_PKT_SEQ_EN
    localparam logic [2:0]       LAST_IDX = 3'd4;
`else
    localparam logic [2:0]       LAST_IDX = 3'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             byte_done;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       cc_q, cc_d;
    logic [7:0]       dc_q, dc_d;
    logic [7:0]       cksum_q, cksum_d;
    logic [7:0]       pkt_count_q, pkt_count_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
`ifdef SENSOR_PKT_SEQ_EN
    logic [7:0]       seq_q, seq_d;
`endif

    // Free-running sample timer; keeps counting regardless of packet activity.
    assign tick = (cnt_q == TICK_AT);

    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign byte_done = (state_q == S_WAIT_DONE) && tx_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (tick) state_d = S_LOAD;
            S_LOAD:      state_d = S_SEND;
            S_SEND:      if (tx_ready) state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (!tx_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_ready) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_SEND;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start    = 1'b0;
        if (state_q == S_SEND) begin
            tx_start = tx_ready;
        end
        dbg_state_o = state_q;
    end

    always_comb begin
        cc_d        = cc_q;
        dc_d        = dc_q;
        cksum_d     = cksum_q;
        idx_d       = idx_q;
        pkt_count_d = pkt_count_q;
        tx_byte_d   = tx_byte_q;
`ifdef SENSOR_PKT_SEQ_EN
        seq_d       = seq_q;
`endif
        busy_d      = (state_d != S_IDLE);
        overrun_d   = overrun_q | (tick & (state_q != S_IDLE));

        if (state_q == S_LOAD) begin
            cc_d    = cc_value;
            dc_d    = dc_value;
            cksum_d = HEADER;
            idx_d   = 3'd0;
`ifdef SENSOR_PKT_SEQ_EN
            seq_d   = pkt_count_q;
`endif
        end

        // HEADER is already the checksum seed, so only the payload bytes are accumulated.
        if (byte_done) begin
            if ((idx_q != 3'd0) && (idx_q != LAST_IDX)) begin
                cksum_d = cksum_q + tx_byte_q;
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == LAST_IDX) begin
                pkt_count_d = pkt_count_q + 8'd1;
            end
        end

        if ((state_d == S_SEND) && (state_q != S_SEND)) begin
            if (idx_d == 3'd0) begin
                tx_byte_d = HEADER;
            end else if (idx_d == LAST_IDX) begin
                tx_byte_d = cksum_d;
`ifdef SENSOR_PKT_SEQ_EN
            end else if (idx_d == 3'd1) begin
                tx_byte_d = seq_q;
            end else if (idx_d == 3'd2) begin
                tx_byte_d = cc_q;
`else
            end else if (idx_d == 3'd1) begin
                tx_byte_d = cc_q;
`endif
            end else begin
                tx_byte_d = dc_q;
            end
        end
    end

    always_ff @(posedge fpga_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_q   <= 8'h00;
            cc_q        <= 8'h00;
            dc_q        <= 8'h00;
            cksum_q     <= 8'h00;
            pkt_count_q <= 8'h00;
            idx_q       <= 3'd0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SENSOR_PKT_SEQ_EN
            seq_q       <= 8'h00;
`endif
        end else begin
            tx_byte_q   <= tx_byte_d;
            cc_q        <= cc_d;
            dc_q        <= dc_d;
            cksum_q     <= cksum_d;
            pkt_count_q <= pkt_count_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef SENSOR_PKT_SEQ_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign tx_byte   = tx_byte_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_sensor_packetizer.sv
// tb_sensor_packetizer: random-stimulus bench with a cycle-level packet model and a uart_send stand-in.
module tb_sensor_packetizer;
    localparam int unsigned SAMPLE_DIV = 16;
    localparam logic [7:0]  HEADER     = 8'hA5;
    localparam int          BUDGET     = 400;
`ifdef SENSOR_PKT_SEQ_EN
    localparam int          PKT_LEN    = 5;
`else
    localparam int          PKT_LEN    = 4;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] cc_value  = 8'h00;
    logic [7:0] dc_value  = 8'h00;
    logic       model_rdy = 1'b1;
    logic       hold_low  = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       busy;
    logic       overrun;
    logic [7:0] pkt_count;
    logic [2:0] dbg_state;

    assign tx_ready = model_rdy & ~hold_low;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int         uart_busy_cyc = 10;
    int         u_phase = 0;
    int         u_left = 0;
    int         m_cnt = 0;
    bit         m_busy = 1'b0;
    bit         m_load_pend = 1'b0;
    bit         m_overrun = 1'b0;
    logic [7:0] m_pkt_count = 8'h00;
    int         m_bytes = 0;
    int         n_starts = 0;
    int         done_pkts = 0;
    int         proto_err = 0;
    int         cyc = 0;
    int         first_start_cyc = -1;
    bit         prev_start = 1'b0;

    sensor_packetizer #(.SAMPLE_DIV(SAMPLE_DIV), .HEADER(HEADER)) dut (
        .fpga_clk1   (clk),
        .rst_n       (rst_n),
        .cc_value    (cc_value),
        .dc_value    (dc_value),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .tx_start    (tx_start),
        .busy        (busy),
        .overrun     (overrun),
        .pkt_count   (pkt_count),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // uart_send stand-in plus packet-level reference model, evaluated mid-cycle.
    always @(negedge clk) begin : model
        logic       s_now;
        logic [7:0] b_now;
        logic [7:0] sum;
        bit         raise_now;
        bit         tk;
        s_now     = tx_start;
        b_now     = tx_byte;
        raise_now = 1'b0;
        if (u_phase == 1) begin
            model_rdy = 1'b0;
            u_left    = uart_busy_cyc;
            u_phase   = 2;
        end else if (u_phase == 2) begin
            u_left--;
            if (u_left <= 0) begin
                model_rdy = 1'b1;
                u_phase   = 0;
                raise_now = 1'b1;
            end
        end
        if (!rst_n) begin
            m_cnt = 0; m_busy = 1'b0; m_load_pend = 1'b0; m_overrun = 1'b0;
            m_pkt_count = 8'h00; m_bytes = 0; n_starts = 0; cyc = 0;
            first_start_cyc = -1; prev_start = 1'b0;
            exp_q.delete();
            got_q.delete();
        end else begin
            if (s_now && !tx_ready) proto_err++;
            if (s_now && prev_start) proto_err++;
            prev_start = s_now;
            if (s_now) begin
                got_q.push_back(b_now);
                n_starts++;
                m_bytes++;
                u_phase = 1;
                if (first_start_cyc < 0) first_start_cyc = cyc;
            end
            if (m_load_pend) begin
                m_load_pend = 1'b0;
                sum = HEADER;
                exp_q.push_back(HEADER);
`ifdef SENSOR_PKT_SEQ_EN
                exp_q.push_back(m_pkt_count);
                sum += m_pkt_count;
`endif
                exp_q.push_back(cc_value);
                sum += cc_value;
                exp_q.push_back(dc_value);
                sum += dc_value;
                exp_q.push_back(sum);
            end
            tk    = (m_cnt == SAMPLE_DIV - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                if (m_busy) begin
                    m_overrun = 1'b1;
                end else begin
                    m_busy      = 1'b1;
                    m_load_pend = 1'b1;
                    m_bytes     = 0;
                end
            end
            if (raise_now && m_busy && (m_bytes == PKT_LEN)) begin
                m_busy = 1'b0;
                m_pkt_count++;
                done_pkts++;
            end
            cyc++;
        end
    end

    task automatic do_reset(input bit hold);
        rst_n    = 1'b0;
        hold_low = hold;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pkts(input int target);
        int c;
        c = 0;
        while (done_pkts < target && c < BUDGET) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (tx_byte !== 8'h00)   begin n_bad++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        n_cmp++; if (tx_start !== 1'b0)   begin n_bad++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (overrun !== 1'b0)    begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_cmp++; if (pkt_count !== 8'h00) begin n_bad++; $display("FAIL reset_pkt_count: got %h expected 00", pkt_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] k [PKT_LEN];
        int target;
`ifdef SENSOR_PKT_SEQ_EN
        k = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hEB};
`else
        k = '{8'hA5, 8'h12, 8'h34, 8'hEB};
`endif
        uart_busy_cyc = 10;
        cc_value = 8'h12;
        dc_value = 8'h34;
        do_reset(1'b0);
        target = done_pkts + 1;
        wait_pkts(target);
        n_cmp++; if (done_pkts < target) begin n_bad++; $display("FAIL basic_timeout: got %0d packets expected %0d", done_pkts, target); end
        n_cmp++; if (first_start_cyc !== SAMPLE_DIV + 1) begin n_bad++; $display("FAIL basic_latency: got cycle %0d expected %0d", first_start_cyc, SAMPLE_DIV + 1); end
        n_cmp++; if (got_q.size() !== PKT_LEN) begin n_bad++; $display("FAIL basic_len: got %0d expected %0d", got_q.size(), PKT_LEN); end
        for (int i = 0; i < PKT_LEN && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== k[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_q[i], k[i]); end
        end
        n_cmp++; if (pkt_count !== 8'd1) begin n_bad++; $display("FAIL basic_pkt_count: got %h expected 01", pkt_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_cmp++; if (overrun !== m_overrun) begin n_bad++; $display("FAIL basic_overrun: got %b expected %b", overrun, m_overrun); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_carry();
        logic [7:0] k [PKT_LEN];
        int target;
`ifdef SENSOR_PKT_SEQ_EN
        k = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hA4};
`else
        k = '{8'hA5, 8'hFF, 8'hFF, 8'hA3};
`endif
        cc_value = 8'hFF;
        dc_value = 8'hFF;
        target = done_pkts + 1;
        wait_pkts(target);
        n_cmp++; if (got_q.size() !== PKT_LEN) begin n_bad++; $display("FAIL carry_len: got %0d expected %0d", got_q.size(), PKT_LEN); end
        for (int i = 0; i < PKT_LEN && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== k[i]) begin n_bad++; $display("FAIL carry_byte%0d: got %h expected %h", i, got_q[i], k[i]); end
        end
        n_cmp++; if (pkt_count !== 8'd2) begin n_bad++; $display("FAIL carry_pkt_count: got %h expected 02", pkt_count); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int target;
        logic [7:0] g, e;
        for (int p = 0; p < 6; p++) begin
            uart_busy_cyc = $urandom_range(1, 12);
            cc_value = 8'($urandom);
            dc_value = 8'($urandom);
            target = done_pkts + 1;
            wait_pkts(target);
            n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL random_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++; if (g !== e) begin n_bad++; $display("FAIL random_byte: got %h expected %h", g, e); end
            end
            got_q.delete();
            exp_q.delete();
        end
        n_cmp++; if (pkt_count !== m_pkt_count) begin n_bad++; $display("FAIL random_pkt_count: got %h expected %h", pkt_count, m_pkt_count); end
        n_cmp++; if (overrun !== m_overrun) begin n_bad++; $display("FAIL random_overrun: got %b expected %b", overrun, m_overrun); end
    endtask

    task automatic test_input_churn();
        int target;
        int c;
        logic [7:0] g, e;
        uart_busy_cyc = 6;
        target = done_pkts + 2;
        c = 0;
        while (done_pkts < target && c < 2 * BUDGET) begin
            @(posedge clk);
            #1;
            cc_value = 8'($urandom);
            dc_value = 8'($urandom);
            c++;
        end
        n_cmp++; if (got_q.size() !== 2 * PKT_LEN) begin n_bad++; $display("FAIL churn_len: got %0d expected %0d", got_q.size(), 2 * PKT_LEN); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL churn_byte: got %h expected %h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_ready_hold();
        int target;
        logic [2:0] s_mid;
        logic [7:0] g, e;
        uart_busy_cyc = 4;
        cc_value = 8'($urandom);
        dc_value = 8'($urandom);
        do_reset(1'b1);
        repeat (60) @(posedge clk);
        #1 s_mid = dbg_state;
        repeat (60) @(posedge clk);
        #1;
        n_cmp++; if (n_starts !== 0) begin n_bad++; $display("FAIL hold_starts: got %0d expected 0", n_starts); end
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL hold_tx_start: got %b expected 0", tx_start); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy: got %b expected 1", busy); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL hold_overrun: got %b expected 1", overrun); end
        n_cmp++; if (dbg_state !== s_mid) begin n_bad++; $display("FAIL hold_state: got %0d expected %0d", dbg_state, s_mid); end
        target = done_pkts + 1;
        hold_low = 1'b0;
        wait_pkts(target);
        n_cmp++; if (got_q.size() !== PKT_LEN) begin n_bad++; $display("FAIL hold_len: got %0d expected %0d", got_q.size(), PKT_LEN); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL hold_byte: got %h expected %h", g, e); end
        end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL hold_overrun_sticky: got %b expected 1", overrun); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int base;
        int c;
        int target;
        logic [7:0] g, e;
        uart_busy_cyc = 10;
        cc_value = 8'($urandom);
        dc_value = 8'($urandom);
        base = n_starts;
        c = 0;
        while (n_starts < base + 3 && c < BUDGET) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++; if (n_starts < base + 3) begin n_bad++; $display("FAIL midrst_timeout: got %0d starts expected %0d", n_starts - base, 3); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_start !== 1'b0)   begin n_bad++; $display("FAIL midrst_tx_start: got %b expected 0", tx_start); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (pkt_count !== 8'h00) begin n_bad++; $display("FAIL midrst_pkt_count: got %h expected 00", pkt_count); end
        n_cmp++; if (tx_byte !== 8'h00)   begin n_bad++; $display("FAIL midrst_tx_byte: got %h expected 00", tx_byte); end
        n_cmp++; if (overrun !== 1'b0)    begin n_bad++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cc_value = 8'($urandom);
        dc_value = 8'($urandom);
        target = done_pkts + 1;
        wait_pkts(target);
        n_cmp++; if (got_q.size() !== PKT_LEN) begin n_bad++; $display("FAIL midrst_len: got %0d expected %0d", got_q.size(), PKT_LEN); end
        n_cmp++; if (got_q.size() > 0 && got_q[0] !== HEADER) begin n_bad++; $display("FAIL midrst_header: got %h expected %h", got_q[0], HEADER); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL midrst_byte: got %h expected %h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        logic [7:0] g, e;
        int target;
        uart_busy_cyc = 2;
        base = m_pkt_count;
        for (int p = 0; p < 257; p++) begin
            cc_value = 8'($urandom);
            dc_value = 8'($urandom);
            target = done_pkts + 1;
            wait_pkts(target);
            if (done_pkts < target) begin
                n_cmp++; n_bad++;
                $display("FAIL b2b_timeout: got %0d packets expected %0d", done_pkts, target);
                break;
            end
            n_cmp++; if (got_q.size() !== PKT_LEN) begin n_bad++; $display("FAIL b2b_len: got %0d expected %0d", got_q.size(), PKT_LEN); end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_byte pkt%0d: got %h expected %h", p, g, e); end
            end
            got_q.delete();
            exp_q.delete();
        end
        n_cmp++; if (pkt_count !== 8'(base + 8'd1)) begin n_bad++; $display("FAIL b2b_pkt_wrap: got %h expected %h", pkt_count, 8'(base + 8'd1)); end
        n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL handshake: got %0d violations expected 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_input_churn();
        test_ready_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
